// File: rtl/char_scroller_if.sv
// Write/display bundle for char_scroller.
//   master: loader/controller side (drives writes, Clear, Enable)
//   slave : scroller side (returns WrReady, CharCode, DigitSel, Length)
interface char_scroller_if #(
   parameter int unsigned DIGITS    = 4,
   parameter int unsigned MSG_DEPTH = 16
);
   localparam int unsigned LW = $clog2(MSG_DEPTH) + 1;

   logic              WrValid;
   logic [5:0]        WrChar;
   logic              WrLast;
   logic              WrReady;
   logic              Clear;
   logic              Enable;
   logic [5:0]        CharCode;
   logic [DIGITS-1:0] DigitSel;
   logic [LW-1:0]     Length;

   modport master (
      output WrValid, WrChar, WrLast, Clear, Enable,
      input  WrReady, CharCode, DigitSel, Length
   );

   modport slave (
      input  WrValid, WrChar, WrLast, Clear, Enable,
      output WrReady, CharCode, DigitSel, Length
   );
endinterface

// File: rtl/char_scroller.sv
// Message buffer and display scanner feeding a char-code to 7-segment decoder.
// Loads 6-bit character codes, then time-multiplexes them over DIGITS
// positions, scrolling with one blank gap when the message is wider than
// the display.
//   Clk_i   : clock, rising edge
//   Reset_i : asynchronous active-high reset
//   bus_io  : char_scroller_if slave (write port, Clear/Enable, scan outputs)
module char_scroller #(
   parameter int unsigned DIGITS     = 4,
   parameter int unsigned MSG_DEPTH  = 16,
   parameter int unsigned SCAN_DIV   = 50000,
   parameter int unsigned SCROLL_DIV = 25000000
) (
   input  logic            Clk_i,
   input  logic            Reset_i,
   char_scroller_if.slave  bus_io
);
   localparam int unsigned LW = $clog2(MSG_DEPTH) + 1;
   localparam int unsigned AW = (MSG_DEPTH > 1) ? $clog2(MSG_DEPTH) : 1;
   localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int unsigned SW = $clog2(SCAN_DIV);
   localparam int unsigned RW = $clog2(SCROLL_DIV);
   localparam logic [5:0]  BLANK = 6'd36;

   typedef enum logic {S_LOAD, S_SHOW} state_e;

   state_e            state_q, state_d;
   logic [LW-1:0]     len_q, len_d;
   logic [LW-1:0]     offset_q, offset_d;
   logic [DW-1:0]     digit_q, digit_d;
   logic [SW-1:0]     scan_q, scan_d;
   logic [RW-1:0]     scroll_q, scroll_d;
   logic [5:0]        char_q, char_d;
   logic [DIGITS-1:0] sel_q, sel_d;
   logic [5:0]        mem_q [MSG_DEPTH];

   logic              wr_mem_c;
   logic [LW:0]       j_c;
   logic [5:0]        show_char_c;

   // Character for the current digit; wide messages wrap over Length+1 slots.
   always_comb begin
      j_c         = (LW+1)'(offset_q) + (LW+1)'(digit_q);
      show_char_c = BLANK;
      if (len_q <= LW'(DIGITS)) begin
         if (LW'(digit_q) < len_q)
            show_char_c = mem_q[AW'(digit_q)];
      end else begin
         // offset <= Length and digit < DIGITS < Length, so one wrap suffices
         if (j_c > (LW+1)'(len_q))
            j_c = j_c - ((LW+1)'(len_q) + (LW+1)'(1));
         if (j_c != (LW+1)'(len_q))
            show_char_c = mem_q[AW'(j_c)];
      end
   end

   // Next-state, counters and registered-output decode.
   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      offset_d = offset_q;
      digit_d  = digit_q;
      scan_d   = scan_q;
      scroll_d = scroll_q;
      char_d   = BLANK;
      sel_d    = '0;
      wr_mem_c = 1'b0;

      if (bus_io.Clear) begin
         // Clear wins over a coincident write and blanks the display at once
         state_d  = S_LOAD;
         len_d    = '0;
         offset_d = '0;
         digit_d  = '0;
         scan_d   = '0;
         scroll_d = '0;
      end else begin
         case (state_q)
            S_LOAD: begin
               if (bus_io.WrValid) begin
                  wr_mem_c = 1'b1;
                  len_d    = len_q + LW'(1);
                  if (bus_io.WrLast || (len_q == LW'(MSG_DEPTH - 1)))
                     state_d = S_SHOW;
               end
            end
            S_SHOW: begin
               sel_d  = DIGITS'(1) << digit_q;
               char_d = show_char_c;

               if (scan_q == SW'(SCAN_DIV - 1)) begin
                  scan_d  = '0;
                  digit_d = (digit_q == DW'(DIGITS - 1)) ? '0 : digit_q + DW'(1);
               end else begin
                  scan_d = scan_q + SW'(1);
               end

               if ((len_q > LW'(DIGITS)) && bus_io.Enable) begin
                  if (scroll_q == RW'(SCROLL_DIV - 1)) begin
                     scroll_d = '0;
                     offset_d = (offset_q == len_q) ? '0 : offset_q + LW'(1);
                  end else begin
                     scroll_d = scroll_q + RW'(1);
                  end
               end
            end
            default: state_d = S_LOAD;
         endcase
      end
   end

   // State and output registers.
   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         state_q  <= S_LOAD;
         len_q    <= '0;
         offset_q <= '0;
         digit_q  <= '0;
         scan_q   <= '0;
         scroll_q <= '0;
         char_q   <= BLANK;
         sel_q    <= '0;
      end else begin
         state_q  <= state_d;
         len_q    <= len_d;
         offset_q <= offset_d;
         digit_q  <= digit_d;
         scan_q   <= scan_d;
         scroll_q <= scroll_d;
         char_q   <= char_d;
         sel_q    <= sel_d;
      end
   end

   // Message storage; contents beyond Length are never displayed.
   always_ff @(posedge Clk_i) begin
      if (wr_mem_c)
         mem_q[AW'(len_q)] <= bus_io.WrChar;
   end

   assign bus_io.WrReady  = (state_q == S_LOAD);
   assign bus_io.CharCode = char_q;
   assign bus_io.DigitSel = sel_q;
   assign bus_io.Length   = len_q;

endmodule

// File: tb/tb_char_scroller.sv
// Directed bench for char_scroller with a queue of predicted display words.
module tb_char_scroller;
   localparam int unsigned DIGITS     = 4;
   localparam int unsigned MSG_DEPTH  = 8;
   localparam int unsigned SCAN_DIV   = 4;
   localparam int unsigned SCROLL_DIV = 16;

   logic clk = 1'b0;
   bit   clk_run = 1'b0;
   logic rst;

   always #5 if (clk_run) clk = ~clk;

   char_scroller_if #(.DIGITS(DIGITS), .MSG_DEPTH(MSG_DEPTH)) bus ();

   char_scroller #(
      .DIGITS(DIGITS), .MSG_DEPTH(MSG_DEPTH),
      .SCAN_DIV(SCAN_DIV), .SCROLL_DIV(SCROLL_DIV)
   ) dut (
      .Clk_i(clk), .Reset_i(rst), .bus_io(bus)
   );

   typedef struct packed {
      logic [DIGITS-1:0] sel;
      logic [5:0]        ch;
   } exp_t;

   exp_t       exp_q[$];
   logic [5:0] msg [MSG_DEPTH];
   int         msg_len = 0;
   int         n_all   = 0;   // SHOW edges since entry
   int         n_en    = 0;   // SHOW edges with scrolling enabled
   int         total   = 0;
   int         bad     = 0;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Output expected after the next edge, from counts before that edge.
   function automatic exp_t predict(input int na, input int ne);
      exp_t e;
      int   d, o, j;
      d     = (na / SCAN_DIV) % DIGITS;
      e.sel = 4'(1) << d;
      if (msg_len <= DIGITS) begin
         e.ch = (d < msg_len) ? msg[d] : 6'd36;
      end else begin
         o    = (ne / SCROLL_DIV) % (msg_len + 1);
         j    = (o + d) % (msg_len + 1);
         e.ch = (j == msg_len) ? 6'd36 : msg[j];
      end
      return e;
   endfunction

   task automatic show_cycles(input int n);
      exp_t e;
      for (int k = 0; k < n; k++) begin
         exp_q.push_back(predict(n_all, n_en));
         @(posedge clk);
         if (msg_len > DIGITS && bus.Enable) n_en++;
         n_all++;
         #1;
         e = exp_q.pop_front();
         check("digitsel", 16'(bus.DigitSel), 16'(e.sel));
         check("charcode", 16'(bus.CharCode), 16'(e.ch));
         check("length_show", 16'(bus.Length), 16'(msg_len));
         check("wrready_show", 16'(bus.WrReady), 16'd0);
      end
   endtask

   task automatic check_load_idle(input string tag, input int exp_len);
      check({tag, "_wrready"}, 16'(bus.WrReady), 16'd1);
      check({tag, "_length"}, 16'(bus.Length), 16'(exp_len));
      check({tag, "_digitsel"}, 16'(bus.DigitSel), 16'd0);
      check({tag, "_charcode"}, 16'(bus.CharCode), 16'd36);
   endtask

   task automatic wr(input logic [5:0] c, input logic last, input int exp_len, input logic exp_ready);
      check("wrready_pre", 16'(bus.WrReady), 16'd1);
      bus.WrValid = 1'b1;
      bus.WrChar  = c;
      bus.WrLast  = last;
      @(posedge clk); #1;
      bus.WrValid = 1'b0;
      bus.WrLast  = 1'b0;
      check("length_wr", 16'(bus.Length), 16'(exp_len));
      check("wrready_post", 16'(bus.WrReady), 16'(exp_ready));
      if (exp_ready) begin
         check("load_digitsel", 16'(bus.DigitSel), 16'd0);
         check("load_charcode", 16'(bus.CharCode), 16'd36);
      end
   endtask

   task automatic load_seq(input int n, input int base, input logic use_last);
      logic lst;
      for (int i = 0; i < n; i++) begin
         msg[i] = 6'(base + i);
         lst    = use_last && (i == n - 1);
         wr(6'(base + i), lst, i + 1, !(lst || (i + 1 == int'(MSG_DEPTH))));
      end
      msg_len = n;
      n_all   = 0;
      n_en    = 0;
   endtask

   task automatic do_clear();
      bus.Clear = 1'b1;
      @(posedge clk); #1;
      bus.Clear = 1'b0;
      check_load_idle("clear", 0);
   endtask

   initial begin
      rst         = 1'b1;
      bus.WrValid = 1'b0;
      bus.WrChar  = '0;
      bus.WrLast  = 1'b0;
      bus.Clear   = 1'b0;
      bus.Enable  = 1'b0;

      // Reset with the clock stopped
      #2;
      check_load_idle("reset", 0);
      clk_run = 1'b1;
      #10 rst = 1'b0;
      @(posedge clk); #1;
      check_load_idle("post_reset", 0);

      // Short message: no scrolling
      bus.Enable = 1'b1;
      load_seq(2, 17, 1'b1);
      show_cycles(100);
      do_clear();

      // Scrolling message through a full wrap, then frozen
      load_seq(6, 0, 1'b1);
      show_cycles(16 * 7 + 24);
      bus.Enable = 1'b0;
      show_cycles(40);
      bus.Enable = 1'b1;
      show_cycles(20);
      do_clear();

      // Buffer full without WrLast; extra write ignored
      load_seq(8, 20, 1'b0);
      bus.WrValid = 1'b1;
      bus.WrChar  = 6'd9;
      show_cycles(3);
      bus.WrValid = 1'b0;
      show_cycles(60);

      // Clear with a coincident write in SHOW
      bus.Clear   = 1'b1;
      bus.WrValid = 1'b1;
      bus.WrChar  = 6'd7;
      @(posedge clk); #1;
      bus.Clear = 1'b0;
      check_load_idle("clear_wr", 0);
      @(posedge clk); #1;
      bus.WrValid = 1'b0;
      check_load_idle("after_clear_wr", 1);
      msg[0] = 6'd7;
      msg[1] = 6'd8;
      wr(6'd8, 1'b1, 2, 1'b0);
      msg_len = 2;
      n_all   = 0;
      n_en    = 0;
      show_cycles(20);
      do_clear();

      // Async reset mid-scroll at offset 3
      load_seq(6, 0, 1'b1);
      show_cycles(16 * 3 + 6);
      #1 rst = 1'b1;
      #1;
      check_load_idle("async_reset", 0);
      #10 rst = 1'b0;
      @(posedge clk); #1;
      check_load_idle("after_async", 0);
      load_seq(2, 10, 1'b1);
      show_cycles(20);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
